// File: rtl/alu_cmd_seq.sv
// Purpose: queues ALU commands in a circular FIFO and sequences each one through
//          an external ALU (drive, wait for ack, hold result for downstream).
// Latency: accept at T0 into empty FIFO/idle FSM -> DRIVE at T1, CAPTURE at T2,
//          out_valid at T3 (with alu_ack=1); one result per 4 cycles when unstalled.
// Backpressure: in_ready = FIFO not full (no bypass when full); result is held
//          stable in HOLD until out_ready; CAPTURE waits indefinitely for alu_ack.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    command handshake; in_a, in_b operands, in_op opcode
//   alu_a/alu_b/alu_s    operands and select driven to the external ALU
//   alu_res/alu_ack      ALU result and its valid strobe
//   out_valid/out_ready  result handshake; out_res, out_op, out_err payload
//   count                FIFO occupancy, 0..DEPTH
module alu_cmd_seq #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  input  logic [3:0]               in_op,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [3:0]               alu_s,
  input  logic [3:0]               alu_res,
  input  logic                     alu_ack,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_res,
  output logic [3:0]               out_op,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // FIFO entry packs {op, a, b}
  logic [11:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic [3:0]    r_a;
  logic [3:0]    r_b;
  logic [3:0]    r_op;

  logic          r_out_vld;
  logic [3:0]    r_out_res;
  logic [3:0]    r_out_op;
  logic          r_out_err;

  logic          w_in_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_capture;
  logic          w_release;
  logic          w_err;

  // Full means not ready, even if a pop happens this edge: no bypass path.
  assign w_in_ready = (r_count != FULL_CNT);
  assign w_push     = in_valid && w_in_ready;

  // Divide (0011) or modulo (1011) by zero.
  assign w_err = ((r_op == 4'b0011) || (r_op == 4'b1011)) && (r_b == 4'h0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and per-state strobes
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_release = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop  = 1'b1;
          w_next = DRIVE;
        end
      end
      DRIVE: begin
        // One cycle of settle time for the ALU.
        w_next = CAPTURE;
      end
      CAPTURE: begin
        if (alu_ack) begin
          w_capture = 1'b1;
          w_next    = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_release = 1'b1;
          w_next    = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {in_op, in_a, in_b};
    end
  end

  // FIFO control, operand registers and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_a       <= 4'h0;
      r_b       <= 4'h0;
      r_op      <= 4'h0;
      r_out_vld <= 1'b0;
      r_out_res <= 4'h0;
      r_out_op  <= 4'h0;
      r_out_err <= 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        {r_op, r_a, r_b} <= r_mem[r_rptr];
        r_rptr           <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_capture) begin
        r_out_res <= w_err ? 4'h0 : alu_res;
        r_out_op  <= r_op;
        r_out_err <= w_err;
        r_out_vld <= 1'b1;
      end else if (w_release) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_s     = r_op;
  assign out_valid = r_out_vld;
  assign out_res   = r_out_res;
  assign out_op    = r_out_op;
  assign out_err   = r_out_err;
  assign count     = r_count;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: directed scenarios plus a randomized run, with a
// scoreboard of expected results filled at command acceptance and drained by
// an output monitor. A behavioural ALU answers the DUT's alu_* pins.
module tb_alu_cmd_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [3:0] in_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_s;
  logic [3:0] alu_res;
  logic       alu_ack;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_res;
  logic [3:0] out_op;
  logic       out_err;
  logic [2:0] count;

  alu_cmd_seq #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_res   (alu_res),
    .alu_ack   (alu_ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_op    (out_op),
    .out_err   (out_err),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] res;
    logic [3:0] op;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  logic [3:0] last_res;
  logic       last_err;

  // Behavioural ALU; division/modulo by zero returns junk the DUT must discard.
  function automatic logic [3:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia;
    int ib;
    int r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      4'd0:    r = ia + ib;
      4'd1:    r = ia - ib;
      4'd2:    r = ia * ib;
      4'd3:    r = (ib != 0) ? ia / ib : 15;
      4'd4:    r = ia & ib;
      4'd5:    r = ia | ib;
      4'd6:    r = ia ^ ib;
      4'd7:    r = ~ia;
      4'd8:    r = ia * 2;
      4'd9:    r = ia / 2;
      4'd11:   r = (ib != 0) ? ia % ib : 10;
      default: r = ia + ib + 1;
    endcase
    return 4'(r);
  endfunction

  assign alu_res = alu_fn(alu_s, alu_a, alu_b);

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    exp_t e;
    e.op  = op;
    e.err = ((op == 4'd3) || (op == 4'd11)) && (b == 4'd0);
    e.res = e.err ? 4'h0 : alu_fn(op, a, b);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Output monitor: a handshake is observed at the negedge before the edge that takes it.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_output", 32'(out_res), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_res", 32'(out_res), 32'(e.res));
        check("sb_op",  32'(out_op),  32'(e.op));
        check("sb_err", 32'(out_err), 32'(e.err));
        last_res = out_res;
        last_err = out_err;
        n_out++;
      end
    end
  end

  // Caller is at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    bit ok;
    ok       = 1'b0;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_valid = 1'b1;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(a, b, op));
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    int         acc;
    int         n_before;
    bit         stable;
    bit         seen;
    bit         done_gen;
    logic [3:0] sa, sb, ss, sr, so;
    logic       se;

    rst = 1'b1; in_valid = 1'b0; in_a = 4'h0; in_b = 4'h0; in_op = 4'h0;
    alu_ack = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_alu_abs",   32'({alu_a, alu_b, alu_s}), 32'd0);
    check("rst_out_payload", 32'({out_res, out_op, out_err}), 32'd0);
    @(posedge clk);
    #1;

    // Basic latency: 3 + 4 = 7
    push_cmd(4'd3, 4'd4, 4'b0000);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k - 1;
        break;
      end
    end
    check("latency_edges", 32'(lat), 32'd3);
    check("first_res", 32'(out_res), 32'd7);
    check("first_op",  32'(out_op),  32'd0);
    check("first_err", 32'(out_err), 32'd0);
    @(posedge clk);
    #1;
    wait_idle();

    // Fill with downstream stalled: one popped plus DEPTH queued
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    for (int n = 0; n < 12; n++) begin
      in_a  = 4'($urandom);
      in_b  = 4'($urandom);
      in_op = 4'($urandom);
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_op));
        acc++;
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("fill_accepted", 32'(acc),      32'd5);
    check("fill_count",    32'(count),    32'd4);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // Divide/modulo by zero handling
    push_cmd(4'd9, 4'd0, 4'b0011);
    wait_idle();
    check("div0_err", 32'(last_err), 32'd1);
    check("div0_res", 32'(last_res), 32'd0);
    push_cmd(4'd9, 4'd4, 4'b1011);
    wait_idle();
    check("mod_err", 32'(last_err), 32'd0);
    check("mod_res", 32'(last_res), 32'd1);

    // ALU ack stall in CAPTURE: 5 - 2 = 3
    alu_ack = 1'b0;
    push_cmd(4'd5, 4'd2, 4'b0001);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    sa = alu_a; sb = alu_b; ss = alu_s;
    check("ack_stall_operands", 32'({sa, sb, ss}), 32'({4'd5, 4'd2, 4'b0001}));
    stable = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (out_valid || alu_a !== sa || alu_b !== sb || alu_s !== ss) stable = 1'b0;
      @(posedge clk);
      #1;
    end
    check("ack_stall_stable", 32'(stable), 32'd1);
    alu_ack = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ack_capture_valid", 32'(out_valid), 32'd1);
    check("ack_capture_res",   32'(out_res),   32'd3);
    @(posedge clk);
    #1;
    wait_idle();

    // Downstream stall in HOLD
    out_ready = 1'b0;
    push_cmd(4'd7, 4'd6, 4'b0110);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("hold_seen_valid", 32'(seen), 32'd1);
    sr = out_res; so = out_op; se = out_err;
    stable = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (!out_valid || out_res !== sr || out_op !== so || out_err !== se) stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("hold_release_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    wait_idle();

    // Reset while in CAPTURE with two queued
    alu_ack = 1'b0;
    push_cmd(4'd1, 4'd2, 4'b0000);
    push_cmd(4'd3, 4'd4, 4'b0101);
    push_cmd(4'd5, 4'd6, 4'b0110);
    @(negedge clk);
    check("prerst_count", 32'(count), 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    n_before = n_out;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_count",     32'(count),     32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    alu_ack = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_output", 32'(n_out), 32'(n_before));

    // Randomized traffic with random stalls on both sides
    done_gen = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          logic [3:0] ra, rb, rop;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          ra  = 4'($urandom);
          rb  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
          rop = 4'($urandom);
          push_cmd(ra, rb, rop);
        end
        done_gen = 1'b1;
      end
      begin
        while (!done_gen) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
          alu_ack   = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    alu_ack   = 1'b1;
    wait_idle();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_outputs", 32'(n_out), 32'(n_before + 150));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
